// File: rtl/imem_loader.sv
// imem_loader
// ----------------------------------------------------------------------------
// Boot-time writer for the 4096 x 19-bit instruction memory. A byte stream
// arrives over a valid/ready handshake; every three bytes are assembled
// big-endian into one 19-bit instruction and written to consecutive addresses
// starting at 0. Loading stops at the all-ones halt word (19'h7FFFF), on a
// malformed first byte, or when the memory fills without a halt word. The CPU
// is held in stall (cpu_hold=1) until loading has finished.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the halt word and must equal the XOR
//   of every byte received before it; otherwise the load ends with error=1.
//   When undefined, the checksum state and register do not exist.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse, begins a load from IDLE or DONE
//   in_data     in   [7:0]  stream byte
//   in_valid    in   in_data is valid
//   in_ready    out  loader accepts a byte this cycle
//   mem_we      out  instruction-memory write strobe, one cycle per word
//   mem_addr    out  [11:0] write address
//   mem_wdata   out  [18:0] instruction to write
//   cpu_hold    out  stalls PC/fetch while high
//   done        out  load finished, held until next start or rst
//   error       out  load aborted or checksum failed, valid while done=1
//   word_count  out  [12:0] words written in the current load, 0..4096
// ----------------------------------------------------------------------------
module imem_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [18:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [12:0] word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, DONE} state_t;
`endif

    localparam logic [18:0] HALT_WORD = 19'h7FFFF;
    localparam logic [11:0] LAST_ADDR = 12'hFFF;

    state_t state;
    logic   accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    // in_ready is a register, so a byte handshake completes on any edge
    // where both sides agree; there is no input-to-output combinational path.
    assign accept = in_valid && in_ready;

    // Single state machine; every output is a register updated alongside the
    // state so that its value matches the state it is entering. mem_wdata is
    // used directly as the assembly register for the word being received.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 12'd0;
            mem_wdata  <= 19'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 13'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= B0;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        mem_addr   <= 12'd0;
                        word_count <= 13'd0;
                        done       <= 1'b0;
                        error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum   <= 8'd0;
`endif
                    end
                end

                B0: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ in_data;
`endif
                        // Only 19 bits exist, so the upper five bits of the
                        // leading byte must be zero; anything else aborts.
                        if (in_data[7:3] != 5'd0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            error    <= 1'b1;
                        end else begin
                            mem_wdata[18:16] <= in_data[2:0];
                            state            <= B1;
                        end
                    end
                end

                B1: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ in_data;
`endif
                        mem_wdata[15:8] <= in_data;
                        state           <= B2;
                    end
                end

                B2: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ in_data;
`endif
                        mem_wdata[7:0] <= in_data;
                        state          <= WRITE;
                        in_ready       <= 1'b0;
                        mem_we         <= 1'b1;
                    end
                end

                WRITE: begin
                    word_count <= word_count + 13'd1;
                    if (mem_wdata == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CHK;
                        in_ready <= 1'b1;
`else
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                        error    <= 1'b0;
`endif
                    end else if (mem_addr == LAST_ADDR) begin
                        // Memory is full and no halt word arrived.
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                        error    <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + 12'd1;
                        state    <= B0;
                        in_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                // The checksum byte itself is not folded into the running XOR.
                CHK: begin
                    if (accept) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                        error    <= (in_data != checksum);
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// ----------------------------------------------------------------------------
// Self-checking bench for imem_loader. Each load's byte stream is run through
// a word-level reference model that predicts the memory writes and the final
// done/error/word_count; predicted writes go into a scoreboard queue that a
// free-running monitor drains whenever mem_we is seen. Works with or without
// IMEM_LOADER_CHECKSUM_EN defined.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [18:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [12:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stim_q[$];
    logic [30:0] exp_q[$];
    logic        prev_we = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the next predicted write, must
    // never coincide with byte acceptance, and must last a single cycle.
    always @(negedge clk) begin
        logic [30:0] e;
        if (mem_we) begin
            checkOutput("we_outside_b_state", {31'd0, in_ready}, 32'd0);
            checkOutput("we_single_cycle", {31'd0, prev_we}, 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write addr=%0h data=%0h expected=none",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", {20'd0, mem_addr}, {20'd0, e[30:19]});
                checkOutput("write_data", {13'd0, mem_wdata}, {13'd0, e[18:0]});
                checkOutput("count_at_write", {19'd0, word_count}, {20'd0, e[30:19]});
            end
        end
        prev_we <= mem_we;
    end

    // Reference model: walks stim_q word by word and predicts writes, the
    // number of bytes the loader will take, and the final error/count.
    task automatic runModel(output int consumed, output logic exp_err, output int exp_cnt);
        int          addr;
        bit          fin;
        logic [18:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0]  ck;
`endif
        addr = 0; consumed = 0; exp_err = 1'b0; exp_cnt = 0; fin = 0;
        while (!fin && consumed < stim_q.size()) begin
            if (stim_q[consumed] > 8'd7) begin
                consumed += 1;
                exp_err = 1'b1;
                fin = 1;
            end else begin
                word = {stim_q[consumed][2:0], stim_q[consumed+1], stim_q[consumed+2]};
                consumed += 3;
                exp_q.push_back({addr[11:0], word});
                exp_cnt++;
                if (word == 19'h7FFFF) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck = 8'd0;
                    for (int i = 0; i < consumed; i++) ck ^= stim_q[i];
                    exp_err = (stim_q[consumed] != ck);
                    consumed += 1;
`endif
                    fin = 1;
                end else if (addr == 4095) begin
                    exp_err = 1'b1;
                    fin = 1;
                end else begin
                    addr++;
                end
            end
        end
    endtask

    // Sends the first n bytes of stim_q. mode 0: valid held high,
    // mode 1: valid alternates every cycle, mode 2: random gaps.
    task automatic applyStimulus(input int n, input int mode);
        bit accepted;
        bit phase;
        int budget;
        phase = 0;
        for (int i = 0; i < n; i++) begin
            accepted = 0;
            budget = 64;
            while (!accepted && budget > 0) begin
                @(negedge clk);
                phase = ~phase;
                if ((mode == 1 && !phase) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    in_data  = stim_q[i];
                end
                accepted = in_valid && in_ready;
                @(posedge clk);
                budget--;
            end
            if (!accepted) begin
                checks++;
                errors++;
                $display("[TB] FAIL byte_accept_timeout index=%0d actual=not_accepted expected=accepted", i);
                #1 in_valid = 1'b0;
                return;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    // Appends the halt word and a correct checksum byte.
    task automatic pushHalt();
        logic [7:0] ck;
        stim_q.push_back(8'h07);
        stim_q.push_back(8'hFF);
        stim_q.push_back(8'hFF);
        ck = 8'd0;
        foreach (stim_q[i]) ck ^= stim_q[i];
        stim_q.push_back(ck);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runLoad(input int mode, input string tag);
        int   n;
        int   cnt;
        int   budget;
        logic e;
        runModel(n, e, cnt);
        pulseStart();
        checkOutput({tag, "_hold_in_load"}, {31'd0, cpu_hold}, 32'd1);
        checkOutput({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_ready_b0"}, {31'd0, in_ready}, 32'd1);
        applyStimulus(n, mode);
        budget = 0;
        while (!done && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, e});
        checkOutput({tag, "_word_count"}, {19'd0, word_count}, cnt);
        checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        checkOutput({tag, "_ready_done"}, {31'd0, in_ready}, 32'd0);
        checkOutput({tag, "_writes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          nw;
        int          bad;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", {13'd0, mem_wdata}, 32'd0);
        checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_word_count", {19'd0, word_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Basic two-word load, continuous then alternating valid.
        stim_q = '{8'h00, 8'h00, 8'h1F};
        pushHalt();
        runLoad(0, "cont");
        runLoad(1, "toggle");

        // Malformed leading byte aborts with no write.
        stim_q = '{8'h20, 8'h00, 8'h00};
        runLoad(0, "badb0");

        // Reset part-way through a word, then a fresh one-word load.
        stim_q = '{8'h00, 8'h00};
        pulseStart();
        applyStimulus(2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("midrst_wdata", {13'd0, mem_wdata}, 32'd0);
        checkOutput("midrst_word_count", {19'd0, word_count}, 32'd0);
        stim_q.delete();
        pushHalt();
        runLoad(0, "after_rst");

        // Randomized loads; the last one hides a malformed leading byte.
        for (int r = 0; r < 4; r++) begin
            stim_q.delete();
            nw  = $urandom_range(1, 12);
            bad = (r == 3) ? $urandom_range(0, nw - 1) : -1;
            for (int w = 0; w < nw; w++) begin
                b0 = 8'($urandom_range(0, 7));
                b1 = 8'($urandom);
                b2 = 8'($urandom);
                if (b0 == 8'h07 && b1 == 8'hFF && b2 == 8'hFF) b2 = 8'h00;
                if (w == bad) b0 = 8'($urandom_range(8, 255));
                stim_q.push_back(b0);
                stim_q.push_back(b1);
                stim_q.push_back(b2);
            end
            pushHalt();
            runLoad(2, "random");
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Corrupted checksum byte.
        stim_q = '{8'h00, 8'h00, 8'h1F};
        pushHalt();
        stim_q[stim_q.size() - 1] = stim_q[stim_q.size() - 1] ^ 8'h01;
        runLoad(0, "bad_cksum");
`endif

        // Fill all of memory without a halt word.
        stim_q.delete();
        for (int w = 0; w < 4096; w++) begin
            stim_q.push_back(8'h00);
            stim_q.push_back(8'h00);
            stim_q.push_back(8'h01);
        end
        runLoad(0, "overflow");
        checkOutput("overflow_last_addr", {20'd0, mem_addr}, 32'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
